// File: rtl/otter_io_pkg.sv
// Shared definitions for the OTTER board I/O glue.
// Holds the memory-mapped I/O addresses, the SPI control/status bit positions,
// the digit index type and the active-low seven-segment hex decoder.
package otter_io_pkg;

    localparam logic [31:0] ADDR_SWITCHES = 32'h1100_0000;
    localparam logic [31:0] ADDR_BUTTONS  = 32'h1100_0004;
    localparam logic [31:0] ADDR_LEDS     = 32'h1108_0000;
    localparam logic [31:0] ADDR_SSEG     = 32'h110C_0000;
    localparam logic [31:0] ADDR_SPI_DATA = 32'h1110_0000;
    localparam logic [31:0] ADDR_SPI_CTRL = 32'h1110_0004;

    localparam int SPI_CTRL_SD_CS  = 0;
    localparam int SPI_CTRL_TFT_CS = 1;
    localparam int SPI_CTRL_TFT_DC = 2;
    localparam int SPI_STAT_BUSY   = 31;

    typedef logic [1:0] digit_idx_t;

    // Segment order {dp,g,f,e,d,c,b,a}, active-low; decimal point always off.
    function automatic logic [7:0] sseg_decode(input logic [3:0] nibble);
        logic [7:0] seg;
        case (nibble)
            4'h0: seg = 8'hC0;
            4'h1: seg = 8'hF9;
            4'h2: seg = 8'hA4;
            4'h3: seg = 8'hB0;
            4'h4: seg = 8'h99;
            4'h5: seg = 8'h92;
            4'h6: seg = 8'h82;
            4'h7: seg = 8'hF8;
            4'h8: seg = 8'h80;
            4'h9: seg = 8'h90;
            4'hA: seg = 8'h88;
            4'hB: seg = 8'h83;
            4'hC: seg = 8'hC6;
            4'hD: seg = 8'hA1;
            4'hE: seg = 8'h86;
            default: seg = 8'h8E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/OTTER_MCU.sv
// Minimal stand-in model of the external pipelined OTTER RV32 core for builds
// that do not include the real core sources. It keeps the I/O bus idle.
// Ports: CLK, RST (sync, active-high), INTR_TIMER/INTR_EXT interrupt levels,
// IOBUS_IN read data, IOBUS_ADDR/IOBUS_OUT/IOBUS_WR bus master outputs.
module OTTER_MCU (
    input  logic        CLK,
    input  logic        RST,
    input  logic        INTR_TIMER,
    input  logic        INTR_EXT,
    input  logic [31:0] IOBUS_IN,
    output logic [31:0] IOBUS_ADDR,
    output logic [31:0] IOBUS_OUT,
    output logic        IOBUS_WR
);

    logic unused_inputs;
    assign unused_inputs = ^{INTR_TIMER, INTR_EXT, IOBUS_IN};

    always_ff @(posedge CLK) begin
        if (RST) begin
            IOBUS_ADDR <= '0;
            IOBUS_OUT  <= '0;
            IOBUS_WR   <= 1'b0;
        end
    end

endmodule

// File: rtl/sseg_driver.sv
// Four-digit multiplexed seven-segment driver.
// Ports: clk, rst (sync, active-high), value[15:0] shown as four hex digits,
// anodes[3:0] active-low digit enables (bit 0 = least significant nibble),
// cathodes[7:0] active-low segments {dp,g,f,e,d,c,b,a}.
module sseg_driver
    import otter_io_pkg::*;
#(
    parameter int REFRESH_BITS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value,
    output logic [3:0]  anodes,
    output logic [7:0]  cathodes
);

    logic [REFRESH_BITS-1:0] refresh_cnt;
    digit_idx_t              digit;

    // Down-counter over 2^REFRESH_BITS cycles; the digit advances on terminal count.
    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_cnt <= '1;
            digit       <= '0;
        end else if (refresh_cnt == '0) begin
            refresh_cnt <= '1;
            digit       <= digit + 1'b1;
        end else begin
            refresh_cnt <= refresh_cnt - 1'b1;
        end
    end

    assign anodes   = ~(4'b0001 << digit);
    assign cathodes = sseg_decode(value[{digit, 2'b00} +: 4]);

endmodule

// File: rtl/otter_wrapper.sv
// Board wrapper for the OTTER core: memory-mapped I/O glue for switches,
// buttons, LEDs, seven-segment display, an 8-bit mode-0 SPI master and the
// interrupt inputs.
// Ports: CLK, BTNC (sync active-high reset), SCLK (SPI bit-rate reference),
// BTNL (button/interrupt), timer_int, m_ext_int, SWITCHES[15:0], LEDS[15:0],
// CATHODES[7:0], ANODES[3:0], SPI_SDI, SPI_SCLK, SPI_SDO, SPI_SD_CS,
// SPI_TFT_CS, TFT_DC.
module otter_wrapper
    import otter_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REFRESH_BITS    = 4
) (
    input  logic        CLK,
    input  logic        BTNC,
    input  logic        SCLK,
    input  logic        BTNL,
    input  logic        timer_int,
    input  logic        m_ext_int,
    input  logic [15:0] SWITCHES,
    output logic [15:0] LEDS,
    output logic [7:0]  CATHODES,
    output logic [3:0]  ANODES,
    input  logic        SPI_SDI,
    output logic        SPI_SCLK,
    output logic        SPI_SDO,
    output logic        SPI_SD_CS,
    output logic        SPI_TFT_CS,
    output logic        TFT_DC
);

    localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LOAD = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [31:0] io_addr;
    logic [31:0] io_out;
    logic [31:0] io_in;
    logic        io_wr;
    logic        intr_ext;

    OTTER_MCU u_core (
        .CLK        (CLK),
        .RST        (BTNC),
        .INTR_TIMER (timer_int),
        .INTR_EXT   (intr_ext),
        .IOBUS_IN   (io_in),
        .IOBUS_ADDR (io_addr),
        .IOBUS_OUT  (io_out),
        .IOBUS_WR   (io_wr)
    );

    logic unused_bus;
    assign unused_bus = ^io_out[31:16];

    // Button debounce: a level is accepted after DEBOUNCE_CYCLES consecutive
    // samples that differ from the current debounced value.
    logic            btnl_meta, btnl_sync, btnl_db, btnl_db_d, btnl_pulse;
    logic [DB_W-1:0] db_cnt;

    always_ff @(posedge CLK) begin
        if (BTNC) begin
            btnl_meta  <= 1'b0;
            btnl_sync  <= 1'b0;
            btnl_db    <= 1'b0;
            btnl_db_d  <= 1'b0;
            btnl_pulse <= 1'b0;
            db_cnt     <= DB_LOAD;
        end else begin
            btnl_meta  <= BTNL;
            btnl_sync  <= btnl_meta;
            btnl_db_d  <= btnl_db;
            btnl_pulse <= btnl_db & ~btnl_db_d;
            if (btnl_sync == btnl_db) begin
                db_cnt <= DB_LOAD;
            end else if (db_cnt == '0) begin
                btnl_db <= btnl_sync;
                db_cnt  <= DB_LOAD;
            end else begin
                db_cnt <= db_cnt - 1'b1;
            end
        end
    end

    assign intr_ext = m_ext_int | btnl_pulse;

    logic [15:0] led_q;
    logic [15:0] sseg_q;
    logic [2:0]  spi_ctrl;

    always_ff @(posedge CLK) begin
        if (BTNC) begin
            led_q    <= '0;
            sseg_q   <= '0;
            spi_ctrl <= '0;
        end else if (io_wr) begin
            case (io_addr)
                ADDR_LEDS:     led_q    <= io_out[15:0];
                ADDR_SSEG:     sseg_q   <= io_out[15:0];
                ADDR_SPI_CTRL: spi_ctrl <= io_out[SPI_CTRL_TFT_DC:SPI_CTRL_SD_CS];
                default: ;
            endcase
        end
    end

    // SPI master: each rising edge of the synchronized SCLK reference toggles
    // SPI_SCLK. MISO is shifted in when SPI_SCLK rises; MOSI shifts when it
    // falls, and the eighth falling edge ends the byte.
    logic       sclk_meta, sclk_sync, sclk_prev, spi_tick;
    logic       spi_busy, spi_sclk_q, spi_data_wr;
    logic [7:0] spi_tx, spi_rx, spi_rx_last;
    logic [2:0] spi_bits;

    assign spi_tick    = sclk_sync & ~sclk_prev;
    assign spi_data_wr = io_wr && (io_addr == ADDR_SPI_DATA);

    always_ff @(posedge CLK) begin
        if (BTNC) begin
            sclk_meta   <= 1'b0;
            sclk_sync   <= 1'b0;
            sclk_prev   <= 1'b0;
            spi_busy    <= 1'b0;
            spi_sclk_q  <= 1'b0;
            spi_tx      <= '0;
            spi_rx      <= '0;
            spi_rx_last <= '0;
            spi_bits    <= '0;
        end else begin
            sclk_meta <= SCLK;
            sclk_sync <= sclk_meta;
            sclk_prev <= sclk_sync;
            if (!spi_busy) begin
                if (spi_data_wr) begin
                    spi_busy   <= 1'b1;
                    spi_sclk_q <= 1'b0;
                    spi_tx     <= io_out[7:0];
                    spi_bits   <= 3'd7;
                end
            end else if (spi_tick) begin
                if (!spi_sclk_q) begin
                    spi_sclk_q <= 1'b1;
                    spi_rx     <= {spi_rx[6:0], SPI_SDI};
                end else begin
                    spi_sclk_q <= 1'b0;
                    spi_tx     <= {spi_tx[6:0], 1'b0};
                    if (spi_bits == '0) begin
                        spi_busy    <= 1'b0;
                        spi_rx_last <= spi_rx;
                    end else begin
                        spi_bits <= spi_bits - 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        io_in = '0;
        case (io_addr)
            ADDR_SWITCHES: io_in = {16'b0, SWITCHES};
            ADDR_BUTTONS:  io_in = {30'b0, btnl_db, BTNC};
            ADDR_LEDS:     io_in = {16'b0, led_q};
            ADDR_SSEG:     io_in = {16'b0, sseg_q};
            ADDR_SPI_DATA: io_in = {24'b0, spi_rx_last};
            ADDR_SPI_CTRL: begin
                io_in[SPI_STAT_BUSY]                   = spi_busy;
                io_in[SPI_CTRL_TFT_DC:SPI_CTRL_SD_CS] = spi_ctrl;
            end
            default: ;
        endcase
    end

    assign LEDS       = led_q;
    assign SPI_SCLK   = spi_sclk_q;
    assign SPI_SDO    = spi_tx[7];
    assign SPI_SD_CS  = ~spi_ctrl[SPI_CTRL_SD_CS];
    assign SPI_TFT_CS = ~spi_ctrl[SPI_CTRL_TFT_CS];
    assign TFT_DC     = spi_ctrl[SPI_CTRL_TFT_DC];

    sseg_driver #(
        .REFRESH_BITS (REFRESH_BITS)
    ) u_sseg (
        .clk      (CLK),
        .rst      (BTNC),
        .value    (sseg_q),
        .anodes   (ANODES),
        .cathodes (CATHODES)
    );

endmodule

// File: tb/tb_otter_wrapper.sv
// Directed bench for otter_wrapper. The core's I/O bus is driven by forcing
// the wrapper's internal bus nets; read data and INTR_EXT are observed inside.
module tb_otter_wrapper;

    logic        CLK = 1'b0;
    logic        SCLK = 1'b0;
    logic        BTNC, BTNL, timer_int, m_ext_int, SPI_SDI;
    logic [15:0] SWITCHES;
    logic [15:0] LEDS;
    logic [7:0]  CATHODES;
    logic [3:0]  ANODES;
    logic        SPI_SCLK, SPI_SDO, SPI_SD_CS, SPI_TFT_CS, TFT_DC;

    logic [31:0] bus_addr, bus_wdata;
    logic        bus_wr;

    int checks = 0;
    int errors = 0;

    always #5  CLK  = ~CLK;
    always #40 SCLK = ~SCLK;

    otter_wrapper #(
        .DEBOUNCE_CYCLES (4),
        .REFRESH_BITS    (4)
    ) dut (
        .CLK        (CLK),
        .BTNC       (BTNC),
        .SCLK       (SCLK),
        .BTNL       (BTNL),
        .timer_int  (timer_int),
        .m_ext_int  (m_ext_int),
        .SWITCHES   (SWITCHES),
        .LEDS       (LEDS),
        .CATHODES   (CATHODES),
        .ANODES     (ANODES),
        .SPI_SDI    (SPI_SDI),
        .SPI_SCLK   (SPI_SCLK),
        .SPI_SDO    (SPI_SDO),
        .SPI_SD_CS  (SPI_SD_CS),
        .SPI_TFT_CS (SPI_TFT_CS),
        .TFT_DC     (TFT_DC)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_bus(input logic [31:0] addr, input logic [31:0] data, input logic wr);
        bus_addr  = addr;
        bus_wdata = data;
        bus_wr    = wr;
        force dut.io_addr = bus_addr;
        force dut.io_out  = bus_wdata;
        force dut.io_wr   = bus_wr;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        drive_bus(addr, data, 1'b1);
        @(posedge CLK);
        @(negedge CLK);
        drive_bus(32'h0, 32'h0, 1'b0);
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        drive_bus(addr, 32'h0, 1'b0);
        #1;
        data = dut.io_in;
    endtask

    logic [3:0]  an_exp  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [7:0]  cat_exp [4] = '{8'hF9, 8'hC0, 8'h8E, 8'h80};

    initial begin
        logic [31:0] rd;
        logic [3:0]  prev_an;
        logic [7:0]  sdo_bits;
        logic        prev_sclk;
        int          n, len, rises, first, pulses;

        BTNC = 1'b1; BTNL = 1'b0; timer_int = 1'b0; m_ext_int = 1'b0;
        SPI_SDI = 1'b0; SWITCHES = 16'h0;
        drive_bus(32'h0, 32'h0, 1'b0);

        // Reset
        @(posedge CLK); @(posedge CLK); @(negedge CLK);
        check("rst_leds", LEDS, 16'h0);
        check("rst_anodes", ANODES, 4'b1110);
        check("rst_cathodes", CATHODES, 8'hC0);
        check("rst_sd_cs", SPI_SD_CS, 1'b1);
        check("rst_tft_cs", SPI_TFT_CS, 1'b1);
        check("rst_tft_dc", TFT_DC, 1'b0);
        check("rst_spi_sclk", SPI_SCLK, 1'b0);
        check("rst_spi_sdo", SPI_SDO, 1'b0);
        bus_read(32'h1100_0004, rd);
        check("rst_btn_read", rd, 32'h0000_0001);
        @(negedge CLK);
        BTNC = 1'b0;
        @(negedge CLK);

        // LED write and readback
        bus_write(32'h1108_0000, 32'h0000_A5A5);
        check("led_out", LEDS, 16'hA5A5);
        bus_read(32'h1108_0000, rd);
        check("led_read", rd, 32'h0000_A5A5);

        // Switch read and unmapped read
        SWITCHES = 16'h1234;
        bus_read(32'h1100_0000, rd);
        check("sw_read", rd, 32'h0000_1234);
        bus_read(32'h2000_0000, rd);
        check("unmapped_read", rd, 32'h0);
        bus_write(32'h2000_0000, 32'hFFFF_FFFF);
        check("unmapped_write_leds", LEDS, 16'hA5A5);

        // Seven-segment: align to the start of digit 0, then walk all slots
        bus_write(32'h110C_0000, 32'h0000_8F01);
        bus_read(32'h110C_0000, rd);
        check("sseg_read", rd, 32'h0000_8F01);
        n = 0;
        do begin
            prev_an = ANODES;
            @(negedge CLK);
            n++;
        end while (!(prev_an != 4'b1110 && ANODES == 4'b1110) && n < 100);
        check("sseg_align_timeout", 32'(n < 100), 32'd1);
        for (int d = 0; d < 4; d++) begin
            check($sformatf("sseg_an%0d", d), ANODES, an_exp[d]);
            check($sformatf("sseg_cat%0d", d), CATHODES, cat_exp[d]);
            len = 0;
            do begin
                @(negedge CLK);
                len++;
            end while (ANODES == an_exp[d] && len < 40);
            check($sformatf("sseg_slot_len%0d", d), len, 32'd16);
        end
        check("sseg_wrap", ANODES, 4'b1110);

        // SPI transfer of 0xA5 with MISO held high
        SPI_SDI = 1'b1;
        bus_write(32'h1110_0004, 32'h0000_0001);
        check("spi_sd_cs", SPI_SD_CS, 1'b0);
        check("spi_tft_cs", SPI_TFT_CS, 1'b1);
        @(negedge SCLK);
        bus_write(32'h1110_0000, 32'h0000_00A5);
        bus_read(32'h1110_0004, rd);
        check("spi_busy_set", rd, 32'h8000_0001);
        bus_write(32'h1110_0000, 32'h0000_003C);
        drive_bus(32'h1110_0004, 32'h0, 1'b0);
        prev_sclk = SPI_SCLK;
        rises = 0; sdo_bits = 8'h0; n = 0;
        while (n < 400) begin
            @(negedge CLK);
            n++;
            if (SPI_SCLK && !prev_sclk) begin
                sdo_bits = {sdo_bits[6:0], SPI_SDO};
                rises++;
            end
            prev_sclk = SPI_SCLK;
            if (dut.io_in[31] == 1'b0) break;
        end
        check("spi_done_timeout", 32'(n < 400), 32'd1);
        check("spi_sclk_pulses", rises, 32'd8);
        check("spi_sdo_bits", sdo_bits, 8'hA5);
        check("spi_sclk_idle", SPI_SCLK, 1'b0);
        bus_read(32'h1110_0000, rd);
        check("spi_rx_byte", rd, 32'h0000_00FF);
        bus_read(32'h1110_0004, rd);
        check("spi_ctrl_idle", rd, 32'h0000_0001);

        // Debounced button interrupt
        @(negedge CLK);
        BTNL = 1'b1;
        first = 0; pulses = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge CLK);
            @(negedge CLK);
            if (dut.intr_ext === 1'b1) begin
                pulses++;
                if (first == 0) first = i;
            end
            if (i == 10) BTNL = 1'b0;
        end
        check("btnl_latency", first, 32'd7);
        check("btnl_pulses", pulses, 32'd1);
        m_ext_int = 1'b1;
        #1;
        check("ext_int_high", dut.intr_ext, 1'b1);
        m_ext_int = 1'b0;
        #1;
        check("ext_int_low", dut.intr_ext, 1'b0);

        // Reset in the middle of a transfer
        @(negedge CLK);
        bus_write(32'h1110_0000, 32'h0000_000F);
        n = 0;
        while (SPI_SCLK !== 1'b1 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        check("rst_mid_wait", 32'(n < 100), 32'd1);
        BTNC = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        BTNC = 1'b0;
        check("rst_mid_sclk", SPI_SCLK, 1'b0);
        check("rst_mid_sd_cs", SPI_SD_CS, 1'b1);
        check("rst_mid_leds", LEDS, 16'h0);
        bus_read(32'h1110_0004, rd);
        check("rst_mid_ctrl", rd, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/otter_wrapper.md
# otter_wrapper

Top-level board wrapper for the pipelined OTTER RV32 core. It instantiates the existing core `OTTER_MCU` and connects its memory-mapped I/O bus to the board peripherals:
- switches and buttons
- LEDs
- a 4-digit seven-segment display
- an 8-bit SPI master for the SD card and TFT
- interrupt inputs

The module is the unit the simulation top and the FPGA top both instantiate. Its own RTL covers only the I/O glue; the core is a dependency.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 4: number of stable `CLK` samples before a button change is accepted.
- `REFRESH_BITS`, default 4: the seven-segment digit advances every 2^`REFRESH_BITS` `CLK` cycles. Synthesis tops override this to 17.

Ports (one clock `CLK`; reset `BTNC`, synchronous, active-high):
- `CLK`  in  1: system clock; all state updates on its rising edge.
- `BTNC`  in  1: synchronous active-high reset of the wrapper and the core.
- `SCLK`  in  1: SPI bit-rate reference, synchronized into the `CLK` domain.
- `BTNL`  in  1: user button, debounced, used as an interrupt source.
- `timer_int`  in  1: machine timer interrupt request, level.
- `m_ext_int`  in  1: machine external interrupt request, level.
- `SWITCHES`  in  16: slide switches.
- `LEDS`  out  16: LED register.
- `CATHODES`  out  8: segment lines `{dp,g,f,e,d,c,b,a}`, active-low.
- `ANODES`  out  4: digit enables, active-low.
- `SPI_SDI`  in  1: SPI MISO.
- `SPI_SCLK`  out  1: SPI clock, mode 0.
- `SPI_SDO`  out  1: SPI MOSI.
- `SPI_SD_CS`  out  1: SD chip select, active-low.
- `SPI_TFT_CS`  out  1: TFT chip select, active-low.
- `TFT_DC`  out  1: TFT data/command select.

## Operation
- Core ports: `RST`=`BTNC`, `IOBUS_ADDR[31:0]`, `IOBUS_OUT[31:0]`, `IOBUS_WR`, `IOBUS_IN[31:0]`, `INTR_TIMER`=`timer_int`, `INTR_EXT`.
- `INTR_EXT` = `m_ext_int` OR a one-cycle pulse generated on each debounced rising edge of `BTNL`.
- I/O map:
  - Writes occur on a `CLK` edge with `IOBUS_WR`=1 and an exact address match.
  - Reads are a combinational mux on `IOBUS_ADDR`.
  - Unmapped reads return 0; unmapped writes are ignored.
- Registers:
  - `0x1100_0000` R: `{16'b0, SWITCHES}`.
  - `0x1100_0004` R: `{30'b0, BTNL_db, BTNC}`.
  - `0x1108_0000` R/W: LEDS, bits [15:0].
  - `0x110C_0000` R/W: SSEG value, bits [15:0].
  - `0x1110_0000` W: start an SPI transfer of bits [7:0]. R: last received byte.
  - `0x1110_0004` R/W: SPI control/status.
    - Bit 0: SD_CS assert.
    - Bit 1: TFT_CS assert.
    - Bit 2: TFT_DC.
    - Bit 31: busy (read-only).
- Seven-segment display:
  - Shows the SSEG value as four hex digits; digit 0 is the least significant nibble, driven by `ANODES[0]`.
  - Exactly one anode is low at any time.
  - The decimal point is always off (`CATHODES[7]`=1).
  - Hex decode is standard, e.g. 0→`8'hC0`, 1→`8'hF9`, 8→`8'h80`, F→`8'h8E`.
- SPI master:
  - `SCLK` passes through a 2-flop synchronizer; a rising-edge detect produces a tick.
  - Each tick toggles `SPI_SCLK` while busy.
  - Data is MSB first. `SPI_SDO` changes on the falling edge; `SPI_SDI` is sampled on the rising edge.
  - After 8 rising edges the transfer ends with `SPI_SCLK`=0, busy clears, and the received byte is latched.
  - A data write while busy is ignored.
  - Chip selects are driven from the control bits: `SPI_SD_CS` = ~bit0, `SPI_TFT_CS` = ~bit1, `TFT_DC` = bit2.

## Timing
- Reset values:
  - `LEDS`=0, SSEG=0, digit index 0, `ANODES`=`4'b1110`, `CATHODES`=`8'hC0`.
  - `SPI_SCLK`=0, `SPI_SDO`=0, `SPI_SD_CS`=1, `SPI_TFT_CS`=1, `TFT_DC`=0.
  - SPI busy=0; debouncers cleared to 0.
- Reset asserted mid-transfer aborts the transfer immediately on the next edge.
- Register writes are visible on outputs one cycle after the write edge. Reads have zero-cycle latency.
- `BTNL` interrupt pulse latency: 2 synchronizer cycles + `DEBOUNCE_CYCLES` + 1 after a stable level change.
- Digit mux wrap-around: 3→0.
- SPI busy asserts the cycle after the data write. One byte takes 16 ticks plus at most 3 `CLK` cycles.

## Structure
- Package `otter_io_pkg`: I/O address constants, SPI control bit indices, and the 16-entry seven-segment decode function.
- Sub-module `sseg_driver`: refresh counter, digit mux, and decode.
- The debouncer is inline logic. The SPI master is inline logic. `OTTER_MCU` is external.

## Test plan
- Reset test: hold `BTNC` for 2 cycles. Require `LEDS`=0, `ANODES`=`4'b1110`, `CATHODES`=`8'hC0`, both chip selects = 1.
- LED write test: bus write `0x1108_0000` ← `0x0000_A5A5`. Require `LEDS`=`16'hA5A5` the next cycle.
- Readback test: read `0x1100_0000` with `SWITCHES`=`16'h1234` → `0x0000_1234`. Unmapped address `0x2000_0000` → 0.
- Seven-segment test: write SSEG=`0x8F01`. Each digit slot of 2^4 cycles shows, in order:
  - `ANODES` `1110` / `CATHODES` `F9`
  - `1101` / `C0`
  - `1011` / `8E`
  - `0111` / `80`
- SPI test: control ← 1, data ← `0xA5`, `SPI_SDI` tied to 1.
  - Require `SPI_SD_CS`=0 and the `SPI_SDO` sequence 1,0,1,0,0,1,0,1.
  - Require 8 `SPI_SCLK` pulses, busy clears, and a data read returns `0xFF`.
  - A second data write during busy is ignored.
- Interrupt test: `BTNL` high for 10 cycles → exactly one `INTR_EXT` pulse. `m_ext_int` held high → `INTR_EXT` high.
